// File: rtl/mem_responder.sv
// Byte-wide RAM plus memory-mapped I/O responder for memctrl: 1-cycle read latency,
// TX byte FIFO with near-full back-pressure, RX holding register and a sticky halt flag.
module mem_responder #(
  parameter int unsigned RAM_AW   = 17,
  parameter int unsigned TX_DEPTH = 8,
  parameter logic [31:0] IO_BASE  = 32'h30000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        iMEM_rw,
  input  logic [31:0] iMEM_addr,
  input  logic [7:0]  iMEM_dt,
  output logic [7:0]  oMEM_dt,
  output logic        oIO_buffer_full,
  output logic        oIO_tx_valid,
  output logic [7:0]  oIO_tx_dt,
  input  logic        iIO_tx_ready,
  input  logic        iIO_rx_valid,
  input  logic [7:0]  iIO_rx_dt,
  output logic        oIO_rx_ready,
  output logic        oHalt
);

  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(TX_DEPTH);
  localparam logic [CW-1:0] FULL_CNT  = CW'(TX_DEPTH - 1);

  logic [7:0] mem_q [2**RAM_AW];
  logic [7:0] tx_buf_q [TX_DEPTH];

  logic [7:0]    rd_q, rd_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] tx_count_q, tx_count_d;
  logic          tx_overflow_q, tx_overflow_d;
  logic          rx_full_q, rx_full_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          halt_q, halt_d;

  logic              io_sel;
  logic [2:0]        io_off;
  logic [RAM_AW-1:0] ram_a;
  logic              ram_we, tx_push_req, tx_push, tx_pop, halt_set, rx_pop;
  logic              unused_bits;

  assign io_sel      = (iMEM_addr[17:16] == IO_BASE[17:16]);
  assign io_off      = iMEM_addr[2:0];
  assign ram_a       = iMEM_addr[RAM_AW-1:0];
  assign unused_bits = ^{iMEM_addr[31:18], iMEM_addr[15:3], IO_BASE};

  always_comb begin
    ram_we      = rdy &  iMEM_rw & ~io_sel;
    tx_push_req = rdy &  iMEM_rw &  io_sel & (io_off == 3'd0);
    halt_set    = rdy &  iMEM_rw &  io_sel & (io_off == 3'd4);
    rx_pop      = rdy & ~iMEM_rw &  io_sel & (io_off == 3'd0) & rx_full_q;
    tx_pop      = (tx_count_q != '0) & iIO_tx_ready;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    tx_push     = tx_push_req & ((tx_count_q != DEPTH_CNT) | tx_pop);
  end

  always_comb begin
    rd_d          = rd_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    tx_count_d    = tx_count_q;
    tx_overflow_d = tx_overflow_q | (tx_push_req & ~tx_push);
    rx_full_d     = rx_full_q;
    rx_byte_d     = rx_byte_q;
    halt_d        = halt_q | halt_set;

    if (rdy && !iMEM_rw) begin
      if (!io_sel) begin
        rd_d = mem_q[ram_a];
      end else begin
        case (io_off)
          3'd0:    rd_d = rx_full_q ? rx_byte_q : 8'h00;
          3'd4:    rd_d = {7'b0, halt_q};
          default: rd_d = 8'h00;
        endcase
      end
    end

    if (tx_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (tx_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + 1'b1;
      2'b01:   tx_count_d = tx_count_q - 1'b1;
      default: tx_count_d = tx_count_q;
    endcase

    // Capture needs an empty register, so it never coincides with a pop.
    if (rx_pop) begin
      rx_full_d = 1'b0;
    end else if (iIO_rx_valid && !rx_full_q) begin
      rx_full_d = 1'b1;
      rx_byte_d = iIO_rx_dt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q          <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      tx_count_q    <= '0;
      tx_overflow_q <= 1'b0;
      rx_full_q     <= 1'b0;
      rx_byte_q     <= '0;
      halt_q        <= 1'b0;
    end else begin
      rd_q          <= rd_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      tx_count_q    <= tx_count_d;
      tx_overflow_q <= tx_overflow_d;
      rx_full_q     <= rx_full_d;
      rx_byte_q     <= rx_byte_d;
      halt_q        <= halt_d;
    end
  end

  // Storage arrays carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (ram_we)  mem_q[ram_a]       <= iMEM_dt;
    if (tx_push) tx_buf_q[wr_ptr_q] <= iMEM_dt;
  end

  assign oMEM_dt         = rd_q;
  assign oIO_tx_valid    = (tx_count_q != '0);
  assign oIO_tx_dt       = tx_buf_q[rd_ptr_q];
  assign oIO_buffer_full = (tx_count_q >= FULL_CNT);
  assign oIO_rx_ready    = ~rx_full_q;
  assign oHalt           = halt_q;

endmodule

// File: doc/mem_responder.md
# mem_responder

Byte-wide memory and memory-mapped I/O responder on the RAM side of `memctrl`. It answers the one-byte-per-cycle read/write stream that `memctrl` drives, with one-cycle read latency from internal block RAM. Accesses to the I/O window go to a TX byte FIFO and an RX holding register. It generates the `io_buffer_full` back-pressure that `memctrl` samples, and sits between `memctrl` and the UART/testbench host.

## Interface
Parameters:
- `RAM_AW`, 17: RAM address bits; RAM depth is 2^RAM_AW bytes.
- `TX_DEPTH`, 8: TX FIFO entries; power of two, ≥ 4.
- `IO_BASE`, 32'h30000: base of the I/O window; decoded on `iMEM_addr[17:16] == 2'b11`.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `rdy` in 1: global enable; when low, no memory side effects occur.
- `iMEM_rw` in 1: 1 = write, 0 = read (matches `Write`/`Read` in `config.v`).
- `iMEM_addr` in 32: byte address.
- `iMEM_dt` in 8: write data.
- `oMEM_dt` out 8: read data, registered.
- `oIO_buffer_full` out 1: TX FIFO near-full back-pressure to `memctrl`.
- `oIO_tx_valid` out 1: TX FIFO non-empty.
- `oIO_tx_dt` out 8: TX FIFO head byte.
- `iIO_tx_ready` in 1: host consumes the head byte when high together with valid.
- `iIO_rx_valid` in 1: host offers an RX byte.
- `iIO_rx_dt` in 8: RX byte.
- `oIO_rx_ready` out 1: RX holding register empty.
- `oHalt` out 1: sticky program-halt flag.

## Operation
Address decode:
- I/O when `iMEM_addr[17:16] == 2'b11`; otherwise RAM at `iMEM_addr[RAM_AW-1:0]`.
- I/O offset: `iMEM_addr[2:0]`. 0 = data port, 4 = halt port. Any other offset reads 0 and ignores writes.

Accepted access (`rdy` = 1 at the posedge):
- RAM write: `mem[a] <= iMEM_dt`.
- RAM read: `oMEM_dt <= mem[a]`.
- I/O write, offset 0: push `iMEM_dt` into the TX FIFO.
  - If the FIFO already holds `TX_DEPTH` entries, drop the byte and set internal sticky `tx_overflow`.
- I/O write, offset 4: set `oHalt`.
- I/O read, offset 0:
  - RX register full: `oMEM_dt <= rx_byte`, and clear the RX register.
  - RX register empty: `oMEM_dt <= 0`.
- I/O read, offset 4: `oMEM_dt <= {7'b0, oHalt}`.
- A write access leaves `oMEM_dt` unchanged.

Behaviour with `rdy` = 0:
- No RAM write, no FIFO push, no RX clear, no halt set.
- `oMEM_dt` holds.
- The TX drain and RX capture on the host side continue regardless of `rdy`.

TX FIFO:
- Circular buffer with wrapping read/write pointers and a count 0..`TX_DEPTH`.
- `oIO_tx_valid = (count != 0)`; `oIO_tx_dt = buf[rd_ptr]`.
- Pop when `oIO_tx_valid && iIO_tx_ready`.
- Simultaneous push and pop: count unchanged, both pointers advance. A push into a full FIFO with a same-cycle pop is accepted.
- `oIO_buffer_full = (count >= TX_DEPTH-1)`, combinational from the count. This leaves room for the one write `memctrl` may issue in the cycle before it observes full.

RX register:
- `oIO_rx_ready = !rx_full`.
- Capture `iIO_rx_dt` when `iIO_rx_valid && oIO_rx_ready`.
- Same-cycle capture and read-pop cannot occur, because capture requires empty.

Reset (asynchronous):
- `oMEM_dt` = 0, TX FIFO empty (pointers and count 0), `oIO_tx_valid` = 0, `oIO_buffer_full` = 0.
- `rx_full` = 0, so `oIO_rx_ready` = 1. `oHalt` = 0, `tx_overflow` = 0.
- RAM contents are not reset; they are preloaded via `$readmemh` for simulation.
- Reset asserted mid-stream discards the in-flight read result and all queued TX bytes.

## Timing
- Read latency is exactly 1 cycle: the address presented at edge N yields `oMEM_dt` valid after edge N. `memctrl` samples it while presenting the next address.
- A write is visible to a read issued on the following cycle. A read and a write cannot share a cycle (single `rw`).
- `oIO_buffer_full` changes in the same cycle as the count; there is no extra register stage.
- TX throughput: 1 byte per cycle when `iIO_tx_ready` is held high.
- An I/O read pop of RX takes effect at the access edge; `oIO_rx_ready` rises the following cycle.

## Test plan
- Preload `mem[0x100..0x103] = 13,00,00,00`. Read 0x100–0x103 on consecutive cycles. Expect `oMEM_dt` = 0x13, 0x00, 0x00, 0x00, each one cycle after its address.
- Write 0xA5 to 0x200, then read 0x200 on the next cycle. Expect 0xA5. Repeat with `rdy` = 0 during the write: expect the old value, and `oMEM_dt` frozen while `rdy` is low.
- With `iIO_tx_ready` = 0, write bytes 1..8 to 0x30000.
  - Expect `oIO_buffer_full` to rise after the 7th push.
  - Expect a 9th write to be dropped and `tx_overflow` = 1.
  - Release ready: expect 1..8 drained in order, with `oIO_tx_valid` falling after 8 cycles.
- With the FIFO full and `iIO_tx_ready` = 1, push 0x55 in the same cycle as a pop. Expect the count to stay at 8, 0x55 emitted last, and no overflow.
- Host offers 0x41 (`oIO_rx_ready` drops). A read of 0x30000 returns 0x41 and `oIO_rx_ready` returns high. A second read returns 0x00.
- Write any value to 0x30004: expect `oHalt` = 1 and a read of 0x30004 = 0x01. Assert `rst` mid-drain: expect `oHalt` = 0, `oIO_tx_valid` = 0, `oMEM_dt` = 0 immediately, without waiting for a clock edge.
